// File: rtl/execute_stage.sv
// Execute stage: ARM-style ALU and load/store address generation with a
// condition-gated NZCV flag register and one-cycle registered outputs.
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] data1_in,
    input  logic [31:0] data2_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  opcode_in,
    input  logic [3:0]  cond_in,
    input  logic        cpsr_write_in,
    input  logic        load_store_in,
    input  logic        up_down_in,
    input  logic        pre_post_in,
    input  logic        byte_word_in,
    input  logic        write_back_in,
    input  logic [3:0]  rd_in,
    output logic [31:0] result_out,
    output logic [31:0] wb_addr_out,
    output logic [31:0] store_data_out,
    output logic [3:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        byte_out,
    output logic        base_wb_out,
    output logic [3:0]  flags_out
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 4;
    localparam int unsigned FW = 4;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } alu_op_e;

    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] store_data_q, store_data_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          byte_q, byte_d;
    logic          base_wb_q, base_wb_d;
    logic [FW-1:0] flags_q, flags_d;

    logic          flag_n, flag_z, flag_c, flag_v;
    logic          cond_pass;
    alu_op_e       alu_op;
    logic          is_mem, is_test, is_logic;
    logic [DW-1:0] op_x, op_y;
    logic          carry_in;
    logic [DW:0]   sum;
    logic [DW-1:0] alu_res;
    logic          alu_c, alu_v;
    logic [DW-1:0] offset;

    assign flag_n  = flags_q[3];
    assign flag_z  = flags_q[2];
    assign flag_c  = flags_q[1];
    assign flag_v  = flags_q[0];
    assign alu_op  = alu_op_e'(opcode_in[3:0]);
    assign is_mem  = opcode_in[4];
    assign is_test = (opcode_in[3:2] == 2'b10);

    // Condition check against the flags as they stand before this instruction
    always_comb begin
        cond_pass = 1'b0;
        case (cond_in)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Shared adder operand selection; subtraction is x + ~y + carry so that C is NOT borrow
    always_comb begin
        op_x     = data1_in;
        op_y     = data2_in;
        carry_in = 1'b0;
        case (alu_op)
            OP_SUB, OP_CMP: begin op_y = ~data2_in; carry_in = 1'b1; end
            OP_RSB:         begin op_x = data2_in; op_y = ~data1_in; carry_in = 1'b1; end
            OP_ADC:         carry_in = flag_c;
            OP_SBC:         begin op_y = ~data2_in; carry_in = flag_c; end
            OP_RSC:         begin op_x = data2_in; op_y = ~data1_in; carry_in = flag_c; end
            default:        carry_in = 1'b0;
        endcase
        sum   = {1'b0, op_x} + {1'b0, op_y} + {{DW{1'b0}}, carry_in};
        alu_c = sum[DW];
        alu_v = (op_x[DW-1] == op_y[DW-1]) && (sum[DW-1] != op_x[DW-1]);
    end

    // Result mux; logical ops leave C and V alone
    always_comb begin
        alu_res  = sum[DW-1:0];
        is_logic = 1'b1;
        case (alu_op)
            OP_AND, OP_TST: alu_res = data1_in & data2_in;
            OP_EOR, OP_TEQ: alu_res = data1_in ^ data2_in;
            OP_ORR:         alu_res = data1_in | data2_in;
            OP_MOV:         alu_res = data2_in;
            OP_BIC:         alu_res = data1_in & ~data2_in;
            OP_MVN:         alu_res = ~data2_in;
            default:        is_logic = 1'b0;
        endcase
    end

    assign offset = up_down_in ? (data1_in + data2_in) : (data1_in - data2_in);

    // Next-state: flush forces a bubble, stall holds, otherwise load the executed instruction
    always_comb begin
        result_d     = result_q;
        wb_addr_d    = wb_addr_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        byte_d       = byte_q;
        base_wb_d    = base_wb_q;
        flags_d      = flags_q;

        if (flush || !stall) begin
            result_d     = is_mem ? (pre_post_in ? offset : data1_in) : alu_res;
            wb_addr_d    = offset;
            store_data_d = store_data_in;
            rd_d         = rd_in;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            byte_d       = 1'b0;
            base_wb_d    = 1'b0;
        end

        if (!flush && !stall && cond_pass) begin
            if (is_mem) begin
                mem_read_d  = load_store_in;
                mem_write_d = !load_store_in;
                byte_d      = byte_word_in;
                base_wb_d   = write_back_in || !pre_post_in;
            end else begin
                reg_write_d = !is_test;
                if (cpsr_write_in || is_test) begin
                    flags_d = {alu_res[DW-1], (alu_res == '0),
                               is_logic ? flag_c : alu_c,
                               is_logic ? flag_v : alu_v};
                end
            end
        end
    end

    // State register with synchronous reset taking priority over stall and flush
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q     <= '0;
            wb_addr_q    <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            byte_q       <= 1'b0;
            base_wb_q    <= 1'b0;
            flags_q      <= '0;
        end else begin
            result_q     <= result_d;
            wb_addr_q    <= wb_addr_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            byte_q       <= byte_d;
            base_wb_q    <= base_wb_d;
            flags_q      <= flags_d;
        end
    end

    assign result_out     = result_q;
    assign wb_addr_out    = wb_addr_q;
    assign store_data_out = store_data_q;
    assign rd_out         = rd_q;
    assign reg_write_out  = reg_write_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign byte_out       = byte_q;
    assign base_wb_out    = base_wb_q;
    assign flags_out      = flags_q;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high; clock clk.
REQ-003 stall  input  1  hold all registered outputs and flags.
REQ-004 flush  input  1  replace the incoming instruction with a bubble.
REQ-005 data1_in  input  32  operand A, Rn value.
REQ-006 data2_in  input  32  operand B, shifted Rm or immediate.
REQ-007 store_data_in  input  32  Rd value for stores.
REQ-008 opcode_in  input  5  [4]=1 memory access, [3:0]=ARM data-processing opcode.
REQ-009 cond_in  input  4  ARM condition field.
REQ-010 cpsr_write_in  input  1  S bit.
REQ-011 load_store_in  input  1  1=load, 0=store; meaningful only when opcode_in[4]=1.
REQ-012 up_down_in  input  1  1=add offset, 0=subtract offset.
REQ-013 pre_post_in  input  1  1=pre-index, 0=post-index.
REQ-014 byte_word_in  input  1  1=byte access.
REQ-015 write_back_in  input  1  base register writeback request.
REQ-016 rd_in  input  4  destination register index.
REQ-017 result_out  output  32  registered ALU result or memory address.
REQ-018 wb_addr_out  output  32  registered updated base value, i.e. data1 ± data2.
REQ-019 store_data_out  output  32  registered store_data_in.
REQ-020 rd_out  output  4  registered rd_in.
REQ-021 reg_write_out, mem_read_out, mem_write_out, byte_out, base_wb_out  output  1 each  registered control.
REQ-022 flags_out  output  4  current NZCV, [3]=N.

Function
REQ-023 Latency SHALL be 1 cycle: inputs sampled at edge k appear on outputs after edge k.
REQ-024 Condition pass SHALL be evaluated from the current flags (pre-update) using standard ARM encodings 0000-1110; 1111 SHALL evaluate false.
- HI = C & !Z; GE = N==V; GT = !Z & (N==V); LE and LS are their complements.
REQ-025 ALU ops, selected by opcode[3:0], SHALL be: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV(=B), BIC, MVN(=~B).
- ADC/SBC/RSC SHALL use the current C flag; SBC = A-B-!C.
REQ-026 All arithmetic SHALL be 32-bit modulo, with a 33-bit carry.
- For subtraction, C SHALL equal NOT borrow.
- V SHALL be signed overflow.
REQ-027 N SHALL equal result[31] and Z SHALL equal (result==0).
- Logical ops SHALL update N and Z only; C and V keep their values.
REQ-028 Flags SHALL update only when all hold: opcode[4]=0, cond passes, and cpsr_write_in=1; with no stall and no flush. TST/TEQ/CMP/CMN SHALL update flags regardless of cpsr_write_in when the cond passes.
REQ-029 reg_write_out SHALL be 1 iff cond passes, opcode[4]=0, and the op is not TST/TEQ/CMP/CMN.
REQ-030 Memory ops (opcode[4]=1), when the cond passes:
- offset = up_down ? A+B : A-B.
- result_out = pre_post ? offset : A.
- wb_addr_out = offset.
- mem_read_out = load_store; mem_write_out = !load_store.
- base_wb_out = write_back_in | !pre_post.
- Flags SHALL be untouched.
REQ-031 A failed condition SHALL produce a bubble: all control outputs 0, flags unchanged; data outputs are don't-care but SHALL still be registered.
REQ-032 flush SHALL produce a bubble at the next edge with flags unchanged.
REQ-033 stall SHALL hold every output and the flags.
- When flush and stall are both asserted, flush SHALL win.
REQ-034 No combinational path SHALL exist from inputs to outputs.

Reset
REQ-035 On reset at a rising edge, all outputs and flags SHALL be 0, overriding stall and flush.
REQ-036 A reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-037 ADDS, A=0x7FFFFFFF, B=1, cond=1110 -> result 0x80000000, NZCV=1001, reg_write=1, rd echoed.
REQ-038 SUBS 5-5, then BEQ-class instruction MOV, cond=0000 -> first yields Z=1, C=1; second executes, reg_write=1.
REQ-039 CMP 3,4 then MOVGE, cond=1010 -> NZCV=1000; MOVGE bubbles, reg_write=0, flags held.
REQ-040 Load, A=0x100, B=8, up=0, pre=0, wb=0 -> result 0x100, wb_addr 0xF8, mem_read=1, base_wb=1.
REQ-041 ADDS issued with stall=1 for 2 cycles, then flush=1 alongside stall -> outputs hold previous values, then become a bubble; flags never change.
REQ-042 Reset pulse mid-stream with stall=1 -> all outputs 0 and NZCV=0000 on the next edge.
